if_id_buffer: RTL and testbench

IF_ID_BUFFER -- requirements
Module: if_id_buffer

---
 rtl/if_id_buffer_pkg.sv | 20 ++
 rtl/if_id_entry.sv | 24 ++
 rtl/if_id_buffer.sv | 145 ++++++++++++++
 tb/tb_if_id_buffer.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/if_id_buffer_pkg.sv
// Shared IF/ID pipeline definitions: buffer state encoding, default widths and NOP.
// Imported by if_id_buffer and if_id_entry.
package if_id_buffer_pkg;

    // Occupancy of the two-entry skid buffer (output register + skid register).
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } buf_state_t;

    localparam int          DEFAULT_IW = 32;
    localparam logic [31:0] NOP_INSTR  = 32'h00000000;

    // The output register carries a live beat in every state except EMPTY.
    function automatic logic holds_beat(input buf_state_t s);
        return (s != EMPTY);
    endfunction

endpackage

// File: rtl/if_id_entry.sv
// One PC+instruction holding register with clock enable and asynchronous reset.
// Used for both the output register and the skid register of if_id_buffer.
module if_id_entry
    import if_id_buffer_pkg::*;
#(
    parameter int             W       = 64,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= RST_VAL;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/if_id_buffer.sv
// IF->ID two-entry skid buffer with a registered in_ready and flush support.
// Optional feature: define IF_ID_STALL_CNT_EN to add a saturating 16-bit stall_cnt output.
//
// Handshake: a beat moves across an interface on a rising edge where valid and ready are
// both 1; valid must not wait for ready, and a producer holds its beat until it moves.
module if_id_buffer
    import if_id_buffer_pkg::*;
#(
    parameter int AW = 32,
    parameter int IW = DEFAULT_IW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [AW-1:0] in_pc,
    input  logic [IW-1:0] in_instr,
    input  logic          flush,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [AW-1:0] out_pc,
    output logic [IW-1:0] out_instr
`ifdef IF_ID_STALL_CNT_EN
    ,
    output logic [15:0]   stall_cnt
`endif
);

    localparam int W = AW + IW;
    localparam logic [W-1:0] ENTRY_RST = {{AW{1'b0}}, IW'(NOP_INSTR)};

    buf_state_t   state_q;
    buf_state_t   state_d;
    logic         in_ready_q;
    logic         push;
    logic         pop;
    logic         out_en;
    logic         out_from_skid;
    logic         skid_en;
    logic [W-1:0] in_beat;
    logic [W-1:0] out_d;
    logic [W-1:0] out_q;
    logic [W-1:0] skid_q;

    assign in_beat = {in_pc, in_instr};
    assign push    = in_valid & in_ready_q & ~flush;
    assign pop     = out_valid & out_ready;

    // State register; in_ready is registered from the next state so it never
    // sees out_ready combinationally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= EMPTY;
            in_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d != FULL);
        end
    end

    always_comb begin
        state_d       = state_q;
        out_en        = 1'b0;
        out_from_skid = 1'b0;
        skid_en       = 1'b0;
        if (flush) begin
            // Flush wins over push and pop; data registers are left untouched.
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (push) begin
                        state_d = ONE;
                        out_en  = 1'b1;
                    end
                end
                ONE: begin
                    if (push && pop) begin
                        out_en = 1'b1;
                    end else if (push) begin
                        state_d = FULL;
                        skid_en = 1'b1;
                    end else if (pop) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    if (pop) begin
                        state_d       = ONE;
                        out_en        = 1'b1;
                        out_from_skid = 1'b1;
                    end
                end
                default: begin
                    state_d = EMPTY;
                end
            endcase
        end
    end

    assign out_d = out_from_skid ? skid_q : in_beat;

    if_id_entry #(
        .W       (W),
        .RST_VAL (ENTRY_RST)
    ) u_out_entry (
        .clk (clk),
        .rst (rst),
        .en  (out_en),
        .d   (out_d),
        .q   (out_q)
    );

    if_id_entry #(
        .W       (W),
        .RST_VAL (ENTRY_RST)
    ) u_skid_entry (
        .clk (clk),
        .rst (rst),
        .en  (skid_en),
        .d   (in_beat),
        .q   (skid_q)
    );

    assign in_ready  = in_ready_q;
    assign out_valid = holds_beat(state_q);
    assign out_pc    = out_q[W-1:IW];
    assign out_instr = out_q[IW-1:0];

`ifdef IF_ID_STALL_CNT_EN
    // Counts cycles the IF stage is blocked; survives flush, saturates at all-ones.
    logic [15:0] stall_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q <= 16'h0000;
        end else if (in_valid && !in_ready_q && (stall_q != 16'hFFFF)) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_if_id_buffer.sv
// Self-checking bench for if_id_buffer: a capacity-2 FIFO model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic with flushes.
module tb_if_id_buffer;

    localparam int AW = 32;
    localparam int IW = 32;
    localparam int W  = AW + IW;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic          in_valid;
    logic          in_ready;
    logic [AW-1:0] in_pc;
    logic [IW-1:0] in_instr;
    logic          flush;
    logic          out_valid;
    logic          out_ready;
    logic [AW-1:0] out_pc;
    logic [IW-1:0] out_instr;
`ifdef IF_ID_STALL_CNT_EN
    logic [15:0]   stall_cnt;
`endif

    if_id_buffer #(.AW(AW), .IW(IW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pc     (in_pc),
        .in_instr  (in_instr),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pc    (out_pc),
        .out_instr (out_instr)
`ifdef IF_ID_STALL_CNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    // ---------------- scoreboard ----------------
    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: the buffer is a FIFO of at most two beats; in_ready reflects
    // whether there was room after the previous edge; flush empties it.
    logic [W-1:0] exp_q[$];
    logic         m_ready;
    logic [W-1:0] m_last;
    logic [15:0]  m_stall;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            exp_q.delete();
            m_ready <= 1'b0;
            m_last  <= '0;
            m_stall <= 16'h0000;
        end else begin
            if (in_valid && !m_ready && (m_stall != 16'hFFFF)) m_stall <= m_stall + 16'd1;
            if (flush) begin
                exp_q.delete();
            end else begin
                if ((exp_q.size() != 0) && out_ready) void'(exp_q.pop_front());
                if (in_valid && m_ready) exp_q.push_back({in_pc, in_instr});
            end
            m_ready <= (exp_q.size() < 2);
            if (exp_q.size() != 0) m_last <= exp_q[0];
        end
    end

    // Compare process: outputs are sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (chk_en && !rst) begin
            check("cmp_in_ready", 64'(in_ready), 64'(m_ready));
            check("cmp_out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
            if (exp_q.size() != 0) check("cmp_out_beat", {out_pc, out_instr}, exp_q[0]);
            else                   check("cmp_out_hold", {out_pc, out_instr}, m_last);
`ifdef IF_ID_STALL_CNT_EN
            check("cmp_stall_cnt", 64'(stall_cnt), 64'(m_stall));
`endif
        end
    end

    // ---------------- driver tasks ----------------
    task automatic idle_inputs();
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        in_pc     = $urandom;
        in_instr  = $urandom;
    endtask

    task automatic drive_beat(input logic [AW-1:0] pc, input logic [IW-1:0] instr);
        in_valid = 1'b1;
        in_pc    = pc;
        in_instr = instr;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        repeat (2) @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_out_pc", 64'(out_pc), 64'd0);
        check("rst_out_instr", 64'(out_instr), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        check("rst_ready_rise", 64'(in_ready), 64'd1);
    endtask

    // ---------------- stimulus ----------------
    logic [AW-1:0] got_pc[$];
    logic [AW-1:0] base_pc;
    bit            rdy_seen;
    bit            acc;

    initial begin
        rst = 1'b1;
        idle_inputs();
        do_reset();
        chk_en = 1'b1;

        // Single beat: one-cycle latency, then empty again.
        out_ready = 1'b1;
        drive_beat(32'h00400000, 32'h20080005);
        @(negedge clk);
        check("s1_valid", 64'(out_valid), 64'd1);
        check("s1_pc", 64'(out_pc), 64'h00400000);
        check("s1_instr", 64'(out_instr), 64'h20080005);
        in_valid = 1'b0;
        @(negedge clk);
        check("s1_drained", 64'(out_valid), 64'd0);

        // Back-to-back stream of 8 beats at full rate.
        base_pc = 32'h00400000;
        for (int k = 0; k <= 8; k++) begin
            if (k > 0) begin
                check("s2_valid", 64'(out_valid), 64'd1);
                check("s2_pc", 64'(out_pc), 64'(base_pc + 32'(4 * (k - 1))));
            end
            if (k < 8) begin
                check("s2_in_ready", 64'(in_ready), 64'd1);
                drive_beat(base_pc + 32'(4 * k), $urandom);
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
        end
        check("s2_drained", 64'(out_valid), 64'd0);

        // Back-pressure: A and B fill the buffer, C waits, then order is A,B,C.
        out_ready = 1'b0;
        drive_beat(32'h0000A000, 32'hAAAA0001);
        @(negedge clk);
        check("s3_ready_after_a", 64'(in_ready), 64'd1);
        drive_beat(32'h0000B000, 32'hBBBB0002);
        @(negedge clk);
        check("s3_ready_after_b", 64'(in_ready), 64'd0);
        drive_beat(32'h0000C000, 32'hCCCC0003);
        @(negedge clk);
        check("s3_c_held", 64'(in_ready), 64'd0);
        out_ready = 1'b1;
        got_pc.delete();
        rdy_seen = in_ready;
        for (int t = 0; t < 10; t++) begin
            if (in_valid && rdy_seen) in_valid = 1'b0;
            if (out_valid) got_pc.push_back(out_pc);
            rdy_seen = in_ready;
            @(negedge clk);
        end
        check("s3_count", 64'(got_pc.size()), 64'd3);
        if (got_pc.size() == 3) begin
            check("s3_first", 64'(got_pc[0]), 64'h0000A000);
            check("s3_second", 64'(got_pc[1]), 64'h0000B000);
            check("s3_third", 64'(got_pc[2]), 64'h0000C000);
        end
        in_valid = 1'b0;

        // Flush in FULL together with beat D: D is discarded, buffer empties.
        out_ready = 1'b0;
        drive_beat(32'h00001000, 32'h11110001);
        @(negedge clk);
        drive_beat(32'h00002000, 32'h22220002);
        @(negedge clk);
        check("s4_full", 64'(in_ready), 64'd0);
        drive_beat(32'h0000D000, 32'hDDDD0004);
        flush = 1'b1;
        @(negedge clk);
        check("s4_valid_low", 64'(out_valid), 64'd0);
        check("s4_ready_high", 64'(in_ready), 64'd1);
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("s4_no_d", 64'(out_valid), 64'd0);
        end

        // Asynchronous reset while holding one beat.
        out_ready = 1'b0;
        drive_beat(32'h00005000, 32'h55550005);
        @(negedge clk);
        check("s5_one", 64'(out_valid), 64'd1);
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("s5_valid_async", 64'(out_valid), 64'd0);
        check("s5_instr_async", 64'(out_instr), 64'd0);
        check("s5_pc_async", 64'(out_pc), 64'd0);
        check("s5_ready_async", 64'(in_ready), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("s5_ready_rise", 64'(in_ready), 64'd1);

        // Randomized traffic with occasional flushes; the IF side holds unaccepted beats.
        idle_inputs();
        rdy_seen = in_ready;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            acc      = in_valid && (flush || rdy_seen);
            rdy_seen = in_ready;
            flush     = ($urandom_range(0, 15) == 0);
            out_ready = (i % 100 < 50) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 2) == 0);
            if (!in_valid || acc) begin
                in_valid = ($urandom_range(0, 3) != 0);
                in_pc    = $urandom;
                in_instr = $urandom;
            end
        end
        idle_inputs();
        @(negedge clk);

`ifdef IF_ID_STALL_CNT_EN
        // Stall counter: five blocked cycles in FULL, unaffected by a later flush.
        do_reset();
        out_ready = 1'b0;
        drive_beat(32'h00006000, 32'h66660006);
        @(negedge clk);
        drive_beat(32'h00007000, 32'h77770007);
        @(negedge clk);
        drive_beat(32'h00008000, 32'h88880008);
        repeat (5) @(negedge clk);
        check("s6_stall_5", 64'(stall_cnt), 64'd5);
        in_valid = 1'b0;
        flush    = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        @(negedge clk);
        check("s6_after_flush", 64'(stall_cnt), 64'd5);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
